// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, funct codes, ALU codes
// and the bit positions inside the 16-bit ex_ctl bundle.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;

  localparam int CTL_MEM_WRITE  = 15;
  localparam int CTL_REG_WRITE  = 14;
  localparam int CTL_MEM_TO_REG = 13;
  localparam int CTL_EXTEND     = 12;
  localparam int CTL_ALU_SRC    = 11;
  localparam int CTL_BRANCH     = 10;
  localparam int CTL_SHIFT16    = 9;
  localparam int CTL_JL         = 8;
  localparam int CTL_HALFWORD   = 7;
  localparam int CTL_BYTE       = 6;
  localparam int CTL_J          = 5;
  localparam int CTL_JR         = 4;
  localparam int CTL_SLTIU      = 3;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational op/func decoder: control bundle, ALU code, destination select and
// source-usage flags. mult/multu/mfhi/mflo decode only with PIPE_CTRL_MULDIV_EN.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int ALU_CTR_W  = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic [5:0]            op,
  input  logic [5:0]            func,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic [15:0]           ctl,
  output logic [ALU_CTR_W-1:0]  alu_ctr,
  output logic [REG_ADDR_W-1:0] dst,
  output logic                  rs_used,
  output logic                  rt_used,
`ifdef PIPE_CTRL_MULDIV_EN
  output logic                  is_mult,
  output logic                  is_mfhilo,
`endif
  output logic                  legal
);

  always_comb begin
    ctl     = '0;
    alu_ctr = ALU_CTR_W'(ALU_ADD);
    rs_used = 1'b1;
    rt_used = 1'b0;
    legal   = 1'b1;
`ifdef PIPE_CTRL_MULDIV_EN
    is_mult   = 1'b0;
    is_mfhilo = 1'b0;
`endif
    if (op == OP_R)
      dst = rd;
    else if (op == OP_JAL)
      dst = {REG_ADDR_W{1'b1}};
    else
      dst = rt;

    case (op)
      OP_R: begin
        rt_used = 1'b1;
        ctl[CTL_REG_WRITE] = 1'b1;
        case (func)
          FN_ADDU: alu_ctr = ALU_CTR_W'(ALU_ADD);
          FN_SUBU: alu_ctr = ALU_CTR_W'(ALU_SUB);
          FN_AND:  alu_ctr = ALU_CTR_W'(ALU_AND);
          FN_OR:   alu_ctr = ALU_CTR_W'(ALU_OR);
          FN_SLTU: alu_ctr = ALU_CTR_W'(ALU_SLTU);
          FN_JR: begin
            ctl[CTL_REG_WRITE] = 1'b0;
            ctl[CTL_JR]        = 1'b1;
          end
`ifdef PIPE_CTRL_MULDIV_EN
          FN_MULT, FN_MULTU: begin
            // Result goes to HI/LO, not the register file.
            ctl[CTL_REG_WRITE] = 1'b0;
            is_mult            = 1'b1;
          end
          FN_MFHI, FN_MFLO: is_mfhilo = 1'b1;
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_LUI: begin
        rs_used = 1'b0;
        ctl[CTL_REG_WRITE] = 1'b1;
        ctl[CTL_ALU_SRC]   = 1'b1;
        ctl[CTL_SHIFT16]   = 1'b1;
      end
      OP_LW, OP_LH, OP_LB: begin
        ctl[CTL_REG_WRITE]  = 1'b1;
        ctl[CTL_MEM_TO_REG] = 1'b1;
        ctl[CTL_EXTEND]     = 1'b1;
        ctl[CTL_ALU_SRC]    = 1'b1;
        ctl[CTL_HALFWORD]   = (op == OP_LH);
        ctl[CTL_BYTE]       = (op == OP_LB);
      end
      OP_SW, OP_SB: begin
        rt_used = 1'b1;
        ctl[CTL_MEM_WRITE] = 1'b1;
        ctl[CTL_EXTEND]    = 1'b1;
        ctl[CTL_ALU_SRC]   = 1'b1;
        ctl[CTL_BYTE]      = (op == OP_SB);
      end
      OP_ORI: begin
        ctl[CTL_REG_WRITE] = 1'b1;
        ctl[CTL_ALU_SRC]   = 1'b1;
        alu_ctr            = ALU_CTR_W'(ALU_OR);
      end
      OP_BEQ: begin
        rt_used = 1'b1;
        ctl[CTL_BRANCH] = 1'b1;
        ctl[CTL_EXTEND] = 1'b1;
        alu_ctr         = ALU_CTR_W'(ALU_SUB);
      end
      OP_JAL: begin
        rs_used = 1'b0;
        ctl[CTL_REG_WRITE] = 1'b1;
        ctl[CTL_JL]        = 1'b1;
        ctl[CTL_J]         = 1'b1;
      end
      OP_J: begin
        rs_used = 1'b0;
        ctl[CTL_J] = 1'b1;
      end
      OP_SLTIU: begin
        ctl[CTL_REG_WRITE] = 1'b1;
        ctl[CTL_EXTEND]    = 1'b1;
        ctl[CTL_ALU_SRC]   = 1'b1;
        ctl[CTL_SLTIU]     = 1'b1;
        alu_ctr            = ALU_CTR_W'(ALU_SLTU);
      end
      default: legal = 1'b0;
    endcase

    // $0 is hard-wired, so writes to it are dropped here and never look like a hazard.
    if (dst == '0)
      ctl[CTL_REG_WRITE] = 1'b0;
    if (!legal) begin
      rs_used = 1'b0;
      rt_used = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control stage: decode, load-use stall, flush-to-bubble and the ID/EX control register.
// Optional HI/LO busy interlock for mult/mfhi is enabled by defining PIPE_CTRL_MULDIV_EN.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALU_CTR_W  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [5:0]            id_op,
  input  logic [5:0]            id_func,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_flush,
  output logic                  out_stall,
  output logic                  ex_valid,
  output logic [15:0]           ex_ctl,
  output logic [ALU_CTR_W-1:0]  ex_alu_ctr,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic                  ex_illegal
);

  logic [15:0]           dec_ctl;
  logic [ALU_CTR_W-1:0]  dec_alu;
  logic [REG_ADDR_W-1:0] dec_dst;
  logic                  rs_used, rt_used, dec_legal;
  logic                  load_use, hazard, issue;

`ifdef PIPE_CTRL_MULDIV_EN
  localparam int BUSY_W = $clog2(MUL_LAT + 1);
  logic              dec_is_mult, dec_is_mfhilo;
  logic [BUSY_W-1:0] busy_reg;
  logic              hilo_wait;
`endif

  ctrl_decode #(
    .ALU_CTR_W (ALU_CTR_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_decode (
    .op       (id_op),
    .func     (id_func),
    .rt       (id_rt),
    .rd       (id_rd),
    .ctl      (dec_ctl),
    .alu_ctr  (dec_alu),
    .dst      (dec_dst),
    .rs_used  (rs_used),
    .rt_used  (rt_used),
`ifdef PIPE_CTRL_MULDIV_EN
    .is_mult  (dec_is_mult),
    .is_mfhilo(dec_is_mfhilo),
`endif
    .legal    (dec_legal)
  );

  assign load_use = id_valid && ex_valid && ex_ctl[CTL_MEM_TO_REG] && ex_ctl[CTL_REG_WRITE] &&
                    ((rs_used && (id_rs == ex_dst)) || (rt_used && (id_rt == ex_dst)));

`ifdef PIPE_CTRL_MULDIV_EN
  assign hilo_wait = id_valid && dec_is_mfhilo && (busy_reg != '0);
  assign hazard    = load_use || hilo_wait;
`else
  assign hazard    = load_use;
`endif

  // A flushed ID instruction is dead, so there is nothing to hold.
  assign out_stall = hazard && !ex_flush;
  assign issue     = !ex_flush && !out_stall && id_valid && dec_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctl     <= '0;
      ex_alu_ctr <= '0;
      ex_dst     <= '0;
      ex_illegal <= 1'b0;
    end else if (issue) begin
      ex_valid   <= 1'b1;
      ex_ctl     <= dec_ctl;
      ex_alu_ctr <= dec_alu;
      ex_dst     <= dec_dst;
      ex_illegal <= 1'b0;
    end else begin
      ex_valid   <= 1'b0;
      ex_ctl     <= '0;
      ex_alu_ctr <= '0;
      ex_dst     <= '0;
      ex_illegal <= !ex_flush && !out_stall && id_valid && !dec_legal;
    end
  end

`ifdef PIPE_CTRL_MULDIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_reg <= '0;
    else if (issue && dec_is_mult)
      busy_reg <= BUSY_W'(MUL_LAT);
    else if (busy_reg != '0)
      busy_reg <= busy_reg - 1'b1;
  end
`endif

endmodule
